// File: rtl/vram_arbiter_if.sv
// vram_arbiter_if -- bus bundle between the VRAM arbiter, the video fetcher,
// the CPU requester and the single-port synchronous RAM.
//
// Groups:
//   video : vid_active, vid_addr (to arbiter); vid_data, vid_valid, vid_stale (from arbiter)
//   cpu   : cpu_req, cpu_we, cpu_addr, cpu_wdata (to arbiter);
//           cpu_ack, cpu_rdata, cpu_wait (from arbiter)
//   ram   : mem_addr, mem_we, mem_wdata (from arbiter); mem_rdata (to arbiter)
//
// Modports:
//   slave  : the arbiter's view
//   master : the environment's view (fetcher, CPU, RAM)
interface vram_arbiter_if #(
    parameter int AW  = 16,
    parameter int DW  = 8,
    parameter int WCW = 8
);
    logic          vid_active;
    logic [AW-1:0] vid_addr;
    logic [DW-1:0] vid_data;
    logic          vid_valid;
    logic          vid_stale;

    logic           cpu_req;
    logic           cpu_we;
    logic [AW-1:0]  cpu_addr;
    logic [DW-1:0]  cpu_wdata;
    logic           cpu_ack;
    logic [DW-1:0]  cpu_rdata;
    logic [WCW-1:0] cpu_wait;

    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  vid_active, vid_addr,
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  mem_rdata,
        output vid_data, vid_valid, vid_stale,
        output cpu_ack, cpu_rdata, cpu_wait,
        output mem_addr, mem_we, mem_wdata
    );

    modport master (
        output vid_active, vid_addr,
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output mem_rdata,
        input  vid_data, vid_valid, vid_stale,
        input  cpu_ack, cpu_rdata, cpu_wait,
        input  mem_addr, mem_we, mem_wdata
    );
endinterface

// File: rtl/vram_arbiter.sv
// vram_arbiter -- shares one single-port synchronous VRAM between the video
// fetcher (one read per clock while vid_active) and a CPU req/ack port.
//
// Ports:
//   clk        video clock
//   reset_n    asynchronous active-low reset
//   bus        vram_arbiter_if.slave (video, CPU and RAM signal groups)
//   state_dbg  current FSM state (0=IDLE, 1=DATA, 2=HOLD)
//
// Optional feature: define VRAM_ARB_STEAL_EN to let a CPU that has waited
// MAX_WAIT cycles steal one video slot (flagged on vid_stale next cycle).
// Without it video has strict priority and vid_stale is constant 0.
//
// CPU handshake: cpu_req is a level, with cpu_we/cpu_addr/cpu_wdata stable
// while it is high. The access is granted (RAM port driven by the CPU) in
// the single IDLE cycle T where cpu_req=1 and video does not own the port;
// cpu_ack pulses for one cycle in T+2 and the requester must drop cpu_req
// then. A cpu_req still high in T+3 starts a new access. cpu_req is
// ignored in DATA and HOLD.
module vram_arbiter #(
    parameter int AW       = 16,
    parameter int DW       = 8,
    parameter int MAX_WAIT = 64,
    parameter int WCW      = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    vram_arbiter_if.slave    bus,
    output logic [1:0]       state_dbg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        HOLD = 2'd2
    } state_t;

`ifdef VRAM_ARB_STEAL_EN
    localparam bit STEAL_EN = 1'b1;
`else
    localparam bit STEAL_EN = 1'b0;
`endif

    localparam logic [WCW-1:0] WAIT_SAT   = '1;
    localparam logic [WCW-1:0] MAX_WAIT_W = WCW'(MAX_WAIT);

    state_t         state, state_nxt;
    logic           cpu_grant;
    logic           steal;
    logic [WCW-1:0] wait_cnt, wait_nxt;
    logic           rd_q;          // granted access was a read
    logic           cpu_ack_q;
    logic [DW-1:0]  cpu_rdata_q;
    logic           vid_valid_q;
    logic           vid_stale_q;

    // With the feature off STEAL_EN folds the comparison away.
    assign steal     = STEAL_EN && (wait_cnt >= MAX_WAIT_W);
    assign cpu_grant = (state == IDLE) && bus.cpu_req && (!bus.vid_active || steal);

    // RAM port mux. The CPU only owns the port in its grant cycle, so video
    // fetches proceed untouched while the FSM is in DATA/HOLD.
    assign bus.mem_addr  = cpu_grant ? bus.cpu_addr : bus.vid_addr;
    assign bus.mem_we    = reset_n && cpu_grant && bus.cpu_we;
    assign bus.mem_wdata = bus.cpu_wdata;

    // Video sees RAM data directly; the RAM's own latency is the only delay.
    assign bus.vid_data  = bus.mem_rdata;
    assign bus.vid_valid = vid_valid_q;
    assign bus.vid_stale = vid_stale_q;

    assign bus.cpu_ack   = cpu_ack_q;
    assign bus.cpu_rdata = cpu_rdata_q;
    assign bus.cpu_wait  = wait_cnt;

    assign state_dbg = state;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cpu_grant) state_nxt = DATA;
            DATA:    state_nxt = HOLD;
            HOLD:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Saturating wait counter: counts only stalled IDLE cycles, holds while
    // an access is in flight, clears on grant or once the request drops.
    always_comb begin
        wait_nxt = wait_cnt;
        if (!bus.cpu_req || cpu_grant) begin
            wait_nxt = '0;
        end else if ((state == IDLE) && (wait_cnt != WAIT_SAT)) begin
            wait_nxt = wait_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            rd_q        <= 1'b0;
            cpu_ack_q   <= 1'b0;
            cpu_rdata_q <= '0;
            vid_valid_q <= 1'b0;
            vid_stale_q <= 1'b0;
        end else begin
            state       <= state_nxt;
            wait_cnt    <= wait_nxt;
            vid_valid_q <= bus.vid_active && !cpu_grant;
            vid_stale_q <= STEAL_EN && cpu_grant && bus.vid_active;
            if (cpu_grant) begin
                rd_q <= !bus.cpu_we;
            end
            case (state)
                DATA: begin
                    // RAM data for the address issued in the grant cycle.
                    cpu_ack_q <= 1'b1;
                    if (rd_q) begin
                        cpu_rdata_q <= bus.mem_rdata;
                    end
                end
                HOLD:    cpu_ack_q <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule
